// File: rtl/sdpram_rd_arbiter.sv
// Round-robin arbiter sharing one SDP RAM read port among NumReq requesters.
// Each issued read carries its requester index down a tag pipeline sized to
// the RAM read latency, so the returning data is strobed to the right client.
module sdpram_rd_arbiter #(
    parameter int NumReq       = 2,
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32,
    parameter int ReadLatency  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             hold,
    input  logic [NumReq-1:0]                req_valid,
    output logic [NumReq-1:0]                req_ready,
    input  logic [NumReq*AddrBusWidth-1:0]   req_addr,
    output logic [NumReq-1:0]                rsp_valid,
    output logic [DataBusWidth-1:0]          rsp_data,
    output logic                             ram_re,
    output logic [AddrBusWidth-1:0]          ram_addr,
    input  logic [DataBusWidth-1:0]          ram_rdata
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdxW-1:0]         ptr;
    logic [IdxW-1:0]         grant_idx;
    logic                    hs;
    logic [AddrBusWidth-1:0] addr_arr [NumReq];
    logic                    last_vld;
    logic [IdxW-1:0]         last_idx;

    // Per-requester address unpack, one-hot grant and one-hot response strobe.
    // Response strobes are masked by reset so nothing leaks out while rst is low.
    for (genvar i = 0; i < NumReq; i++) begin : g_req
        assign addr_arr[i]  = req_addr[i*AddrBusWidth +: AddrBusWidth];
        assign req_ready[i] = hs && (grant_idx == IdxW'(i));
        assign rsp_valid[i] = rst && last_vld && (last_idx == IdxW'(i));
    end

    // Scan upward from the priority pointer; first valid requester wins.
    always_comb begin
        int j;
        j         = 0;
        hs        = 1'b0;
        grant_idx = '0;
        if (rst && !hold) begin
            for (int k = 0; k < NumReq; k++) begin
                j = (int'(ptr) + k) % NumReq;
                if (!hs && req_valid[j]) begin
                    hs        = 1'b1;
                    grant_idx = IdxW'(j);
                end
            end
        end
    end

    assign ram_re   = hs;
    assign ram_addr = hs ? addr_arr[grant_idx] : '0;

    // Pointer moves just past the winner, wrapping at NumReq-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (grant_idx == IdxW'(NumReq-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    if (ReadLatency == 0) begin : g_lat0
        // Zero-latency RAM: the response is the handshake itself.
        assign last_vld = hs;
        assign last_idx = grant_idx;
    end else begin : g_latn
        logic [ReadLatency-1:0]           vld_pipe;
        logic [ReadLatency-1:0][IdxW-1:0] idx_pipe;

        // Tag shift register; advances every cycle since responses cannot stall.
        always_ff @(posedge clk) begin
            if (!rst) begin
                vld_pipe <= '0;
                idx_pipe <= '0;
            end else begin
                vld_pipe[0] <= hs;
                idx_pipe[0] <= grant_idx;
                for (int s = 1; s < ReadLatency; s++) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    idx_pipe[s] <= idx_pipe[s-1];
                end
            end
        end

        assign last_vld = vld_pipe[ReadLatency-1];
        assign last_idx = idx_pipe[ReadLatency-1];
    end

    assign rsp_data = (|rsp_valid) ? ram_rdata : '0;

endmodule

// File: tb/tb_sdpram_rd_arbiter.sv
// Directed bench: a 3-requester / latency-2 instance (A) and a
// 2-requester / latency-0 instance (B), each fed by a small RAM model
// whose content at address a is 0xD0000000 | a.
module tb_sdpram_rd_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        hold;

    logic [2:0]  rv, rr, rsv;
    logic [95:0] ra;
    logic        re;
    logic [31:0] raddr, rdata, rsd;

    logic [1:0]  rv_b, rr_b, rsv_b;
    logic [63:0] ra_b;
    logic        re_b;
    logic [31:0] raddr_b, rdata_b, rsd_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdpram_rd_arbiter #(.NumReq(3), .AddrBusWidth(32), .DataBusWidth(32), .ReadLatency(2)) dut_a (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(rv), .req_ready(rr), .req_addr(ra),
        .rsp_valid(rsv), .rsp_data(rsd),
        .ram_re(re), .ram_addr(raddr), .ram_rdata(rdata)
    );

    sdpram_rd_arbiter #(.NumReq(2), .AddrBusWidth(32), .DataBusWidth(32), .ReadLatency(0)) dut_b (
        .clk(clk), .rst(rst), .hold(1'b0),
        .req_valid(rv_b), .req_ready(rr_b), .req_addr(ra_b),
        .rsp_valid(rsv_b), .rsp_data(rsd_b),
        .ram_re(re_b), .ram_addr(raddr_b), .ram_rdata(rdata_b)
    );

    // RAM models: two-cycle registered read for A, combinational for B
    logic [31:0] a1, a2;
    always @(posedge clk) begin
        a1 <= raddr;
        a2 <= a1;
    end
    assign rdata   = 32'hD000_0000 | a2;
    assign rdata_b = 32'hD000_0000 | raddr_b;

    function automatic logic [31:0] addr_a(input logic [2:0] oh);
        case (oh)
            3'b001:  return 32'h10;
            3'b010:  return 32'h20;
            3'b100:  return 32'h30;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] addr_b(input logic [1:0] oh);
        case (oh)
            2'b01:   return 32'h40;
            2'b10:   return 32'h50;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] data_a(input logic [2:0] oh);
        return (oh != 3'b000) ? (32'hD000_0000 | addr_a(oh)) : 32'h0;
    endfunction

    function automatic logic [31:0] data_b(input logic [1:0] oh);
        return (oh != 2'b00) ? (32'hD000_0000 | addr_b(oh)) : 32'h0;
    endfunction

    task automatic test_reset();
        rst = 1'b0; hold = 1'b0; rv = 3'b111; rv_b = 2'b11;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({rr, re, raddr, rsv, rsd} !== 71'h0) begin
                bad++;
                $display("FAIL reset_a cyc %0d: got rr=%b re=%b addr=%h rsv=%b data=%h want all 0",
                         c, rr, re, raddr, rsv, rsd);
            end
            total++;
            if ({rr_b, re_b, raddr_b, rsv_b, rsd_b} !== 69'h0) begin
                bad++;
                $display("FAIL reset_b cyc %0d: got rr=%b re=%b addr=%h rsv=%b data=%h want all 0",
                         c, rr_b, re_b, raddr_b, rsv_b, rsd_b);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1; rv = 3'b000; rv_b = 2'b00;
        @(negedge clk);
        total++;
        if ({rr, re, rsv} !== 7'h0) begin
            bad++;
            $display("FAIL reset_idle: got rr=%b re=%b rsv=%b want 0", rr, re, rsv);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency0();
        logic [1:0] rvs [4] = '{2'b01, 2'b11, 2'b11, 2'b00};
        logic [1:0] ers [4] = '{2'b01, 2'b10, 2'b01, 2'b00};
        for (int c = 0; c < 4; c++) begin
            rv_b = rvs[c];
            @(negedge clk);
            total++;
            if ({rr_b, re_b, raddr_b} !== {ers[c], |ers[c], addr_b(ers[c])}) begin
                bad++;
                $display("FAIL lat0_grant cyc %0d: got rr=%b re=%b addr=%h want rr=%b addr=%h",
                         c, rr_b, re_b, raddr_b, ers[c], addr_b(ers[c]));
            end
            total++;
            if ({rsv_b, rsd_b} !== {ers[c], data_b(ers[c])}) begin
                bad++;
                $display("FAIL lat0_rsp cyc %0d: got rsv=%b data=%h want rsv=%b data=%h",
                         c, rsv_b, rsd_b, ers[c], data_b(ers[c]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] rvs [8] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};
        logic [2:0] ers [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
        logic [2:0] evs [8] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int c = 0; c < 8; c++) begin
            rv = rvs[c]; hold = 1'b0;
            @(negedge clk);
            total++;
            if ({rr, re, raddr} !== {ers[c], |ers[c], addr_a(ers[c])}) begin
                bad++;
                $display("FAIL rr_grant cyc %0d: got rr=%b re=%b addr=%h want rr=%b addr=%h",
                         c, rr, re, raddr, ers[c], addr_a(ers[c]));
            end
            total++;
            if ({rsv, rsd} !== {evs[c], data_a(evs[c])}) begin
                bad++;
                $display("FAIL rr_rsp cyc %0d: got rsv=%b data=%h want rsv=%b data=%h",
                         c, rsv, rsd, evs[c], data_a(evs[c]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        logic [2:0] rvs [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        logic [2:0] ers [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        logic [2:0] evs [6] = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010};
        for (int c = 0; c < 6; c++) begin
            rv = rvs[c]; hold = 1'b0;
            @(negedge clk);
            total++;
            if ({rr, re, raddr} !== {ers[c], |ers[c], addr_a(ers[c])}) begin
                bad++;
                $display("FAIL single_grant cyc %0d: got rr=%b re=%b addr=%h want rr=%b addr=%h",
                         c, rr, re, raddr, ers[c], addr_a(ers[c]));
            end
            total++;
            if ({rsv, rsd} !== {evs[c], data_a(evs[c])}) begin
                bad++;
                $display("FAIL single_rsp cyc %0d: got rsv=%b data=%h want rsv=%b data=%h",
                         c, rsv, rsd, evs[c], data_a(evs[c]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        logic [2:0] rvs [7] = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        logic       hds [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] ers [7] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
        logic [2:0] evs [7] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b001};
        for (int c = 0; c < 7; c++) begin
            rv = rvs[c]; hold = hds[c];
            @(negedge clk);
            total++;
            if ({rr, re, raddr} !== {ers[c], |ers[c], addr_a(ers[c])}) begin
                bad++;
                $display("FAIL hold_grant cyc %0d: got rr=%b re=%b addr=%h want rr=%b addr=%h",
                         c, rr, re, raddr, ers[c], addr_a(ers[c]));
            end
            total++;
            if ({rsv, rsd} !== {evs[c], data_a(evs[c])}) begin
                bad++;
                $display("FAIL hold_rsp cyc %0d: got rsv=%b data=%h want rsv=%b data=%h",
                         c, rsv, rsd, evs[c], data_a(evs[c]));
            end
            @(posedge clk); #1;
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic       rsts [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0] rvs  [6] = '{3'b010, 3'b101, 3'b101, 3'b101, 3'b000, 3'b000};
        logic [2:0] ers  [6] = '{3'b010, 3'b000, 3'b001, 3'b100, 3'b000, 3'b000};
        logic [2:0] evs  [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b100};
        for (int c = 0; c < 6; c++) begin
            rst = rsts[c]; rv = rvs[c]; hold = 1'b0;
            @(negedge clk);
            total++;
            if ({rr, re, raddr} !== {ers[c], |ers[c], addr_a(ers[c])}) begin
                bad++;
                $display("FAIL rstmid_grant cyc %0d: got rr=%b re=%b addr=%h want rr=%b addr=%h",
                         c, rr, re, raddr, ers[c], addr_a(ers[c]));
            end
            total++;
            if ({rsv, rsd} !== {evs[c], data_a(evs[c])}) begin
                bad++;
                $display("FAIL rstmid_rsp cyc %0d: got rsv=%b data=%h want rsv=%b data=%h",
                         c, rsv, rsd, evs[c], data_a(evs[c]));
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    task automatic test_wrap();
        logic [2:0] rvs [6] = '{3'b010, 3'b101, 3'b101, 3'b101, 3'b000, 3'b000};
        logic [2:0] ers [6] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b000, 3'b000};
        logic [2:0] evs [6] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b100};
        for (int c = 0; c < 6; c++) begin
            rv = rvs[c]; hold = 1'b0;
            @(negedge clk);
            total++;
            if ({rr, re, raddr} !== {ers[c], |ers[c], addr_a(ers[c])}) begin
                bad++;
                $display("FAIL wrap_grant cyc %0d: got rr=%b re=%b addr=%h want rr=%b addr=%h",
                         c, rr, re, raddr, ers[c], addr_a(ers[c]));
            end
            total++;
            if ({rsv, rsd} !== {evs[c], data_a(evs[c])}) begin
                bad++;
                $display("FAIL wrap_rsp cyc %0d: got rsv=%b data=%h want rsv=%b data=%h",
                         c, rsv, rsd, evs[c], data_a(evs[c]));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst  = 1'b0;
        hold = 1'b0;
        rv   = 3'b000;
        rv_b = 2'b00;
        ra   = {32'h30, 32'h20, 32'h10};
        ra_b = {32'h50, 32'h40};
        test_reset();
        test_latency0();
        test_round_robin();
        test_single();
        test_hold();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
